// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, state encodings and helpers for the HD44780 text driver
// Provides LCD command bytes, the one-hot main FSM encoding, the write-strobe phase
// encoding, the printable-character filter and the init command table.
package lcd_pkg;
    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;

    typedef enum logic [6:0] {
        ST_POWERUP = 7'b000_0001,
        ST_INIT    = 7'b000_0010,
        ST_SNAP    = 7'b000_0100,
        ST_ADDR1   = 7'b000_1000,
        ST_LINE1   = 7'b001_0000,
        ST_ADDR2   = 7'b010_0000,
        ST_LINE2   = 7'b100_0000
    } lcd_state_e;

    typedef enum logic [1:0] {
        PH_IDLE,
        PH_SETUP,
        PH_PULSE,
        PH_WAIT
    } wr_phase_e;

    function automatic logic [7:0] lcd_printable(input logic [7:0] c);
        return (c < 8'h20 || c > 8'h7E) ? ASCII_SPACE : c;
    endfunction

    function automatic logic [7:0] lcd_init_cmd(input logic [1:0] idx);
        return idx == 2'd0 ? LCD_FUNC_SET :
               idx == 2'd1 ? LCD_DISP_ON  :
               idx == 2'd2 ? LCD_ENTRY    : LCD_CLEAR;
    endfunction
endpackage

// File: rtl/lcd_write_strobe.sv
// lcd_write_strobe: one LCD bus write as SETUP (1 cycle), PULSE (E high), WAIT (E low)
// Ports: clk_i/rst_i clock and sync active-high reset; start_i launches a write with
// rs_i/data_i/wait_cycles_i; lcd_e_o/lcd_rs_o/lcd_data_o drive the bus; busy_o is high
// while a write is in flight; done_o pulses in the last WAIT cycle so a new start can
// be accepted in that same cycle with no idle gap.
module lcd_write_strobe
    import lcd_pkg::*;
#(
    parameter int E_PULSE_CYCLES = 24,
    parameter int CNT_W          = 21
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             rs_i,
    input  logic [7:0]       data_i,
    input  logic [CNT_W-1:0] wait_cycles_i,
    output logic             lcd_e_o,
    output logic             lcd_rs_o,
    output logic [7:0]       lcd_data_o,
    output logic             busy_o,
    output logic             done_o
);
    wr_phase_e        phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, wait_q, wait_d;
    logic             e_q, rs_q, rs_d;
    logic [7:0]       data_q, data_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + 1'b1;
        wait_d  = wait_q;
        rs_d    = rs_q;
        data_d  = data_q;
        done_o  = 1'b0;
        case (phase_q)
            PH_SETUP: begin
                phase_d = PH_PULSE;
                cnt_d   = '0;
            end
            PH_PULSE: if (cnt_q == CNT_W'(E_PULSE_CYCLES - 1)) begin
                phase_d = PH_WAIT;
                cnt_d   = '0;
            end
            PH_WAIT: if (cnt_q == wait_q - 1'b1) begin
                phase_d = PH_IDLE;
                done_o  = 1'b1;
            end
            default: cnt_d = '0;
        endcase
        // rs/data are captured only here, so they hold through WAIT until the next SETUP
        if (start_i) begin
            phase_d = PH_SETUP;
            rs_d    = rs_i;
            data_d  = data_i;
            wait_d  = wait_cycles_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= PH_IDLE;
            cnt_q   <= '0;
            wait_q  <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
            e_q     <= phase_d == PH_PULSE;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    assign lcd_e_o    = e_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_data_o = data_q;
    assign busy_o     = phase_q != PH_IDLE;
endmodule

// File: rtl/lcd_text_driver.sv
// lcd_text_driver: refreshes a 16x2 HD44780 LCD (8-bit mode) from a 256-bit text vector
// Ports: Clk/reset clock and sync active-high reset; text_in holds char 0 at [255:248]
// through char 31 at [7:0]; lcd_e/lcd_rs/lcd_rw/lcd_data drive the LCD; init_done goes
// high after the init sequence; frame_done pulses once per completed 34-write frame.
module lcd_text_driver
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYCLES    = 1500000,
    parameter int E_PULSE_CYCLES    = 24,
    parameter int CMD_WAIT_CYCLES   = 4000,
    parameter int CLEAR_WAIT_CYCLES = 164000
) (
    input  logic         Clk,
    input  logic         reset,
    input  logic [255:0] text_in,
    output logic         lcd_e,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_data,
    output logic         init_done,
    output logic         frame_done
);
    localparam int MAX_A    = POWERUP_CYCLES > CLEAR_WAIT_CYCLES ? POWERUP_CYCLES : CLEAR_WAIT_CYCLES;
    localparam int MAX_B    = E_PULSE_CYCLES > CMD_WAIT_CYCLES ? E_PULSE_CYCLES : CMD_WAIT_CYCLES;
    localparam int MAX_WAIT = MAX_A > MAX_B ? MAX_A : MAX_B;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cmd_q, cmd_d;
    logic [4:0]       chr_q, chr_d;
    logic [255:0]     snap_q, snap_d;
    logic             init_done_q, init_done_d, frame_done_q, frame_done_d;
    logic             wr_start, wr_rs, wr_busy, wr_done;
    logic [7:0]       wr_data;
    logic [CNT_W-1:0] wr_wait;

    // A write is launched in the cycle the FSM moves onto its item, so the item's
    // rs/data are derived from the next-state values.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cmd_d        = cmd_q;
        chr_d        = chr_q;
        snap_d       = snap_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        wr_start     = 1'b0;
        case (state_q)
            ST_POWERUP: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(POWERUP_CYCLES - 1)) begin
                    state_d  = ST_INIT;
                    cnt_d    = '0;
                    cmd_d    = 2'd0;
                    wr_start = 1'b1;
                end
            end
            ST_INIT: if (wr_done) begin
                cmd_d    = cmd_q + 1'b1;
                wr_start = cmd_q != 2'd3;
                if (cmd_q == 2'd3) begin
                    state_d     = ST_SNAP;
                    init_done_d = 1'b1;
                end
            end
            ST_SNAP: begin
                snap_d   = text_in;
                chr_d    = '0;
                state_d  = ST_ADDR1;
                wr_start = 1'b1;
            end
            ST_ADDR1: if (wr_done) begin
                state_d  = ST_LINE1;
                wr_start = 1'b1;
            end
            ST_LINE1: if (wr_done) begin
                chr_d    = chr_q + 1'b1;
                wr_start = 1'b1;
                if (chr_q == 5'd15) state_d = ST_ADDR2;
            end
            ST_ADDR2: if (wr_done) begin
                state_d  = ST_LINE2;
                wr_start = 1'b1;
            end
            ST_LINE2: if (wr_done) begin
                if (chr_q == 5'd31) begin
                    state_d      = ST_SNAP;
                    frame_done_d = 1'b1;
                end else begin
                    chr_d    = chr_q + 1'b1;
                    wr_start = 1'b1;
                end
            end
            default: state_d = ST_POWERUP;
        endcase
    end

    // ~chr_d selects char 31-chr_d's byte lane, i.e. char 0 sits in the top byte
    assign wr_rs   = state_d == ST_LINE1 || state_d == ST_LINE2;
    assign wr_data = state_d == ST_INIT  ? lcd_init_cmd(cmd_d) :
                     state_d == ST_ADDR1 ? LCD_LINE1 :
                     state_d == ST_ADDR2 ? LCD_LINE2 :
                     lcd_printable(snap_q[{~chr_d, 3'b000} +: 8]);
    assign wr_wait = (!wr_rs && wr_data == LCD_CLEAR) ? CNT_W'(CLEAR_WAIT_CYCLES) : CNT_W'(CMD_WAIT_CYCLES);

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q      <= ST_POWERUP;
            cnt_q        <= '0;
            cmd_q        <= 2'd0;
            chr_q        <= 5'd0;
            snap_q       <= '0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            chr_q        <= chr_d;
            snap_q       <= snap_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    lcd_write_strobe #(
        .E_PULSE_CYCLES(E_PULSE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_strobe (
        .clk_i        (Clk),
        .rst_i        (reset),
        .start_i      (wr_start && (!wr_busy || wr_done)),
        .rs_i         (wr_rs),
        .data_i       (wr_data),
        .wait_cycles_i(wr_wait),
        .lcd_e_o      (lcd_e),
        .lcd_rs_o     (lcd_rs),
        .lcd_data_o   (lcd_data),
        .busy_o       (wr_busy),
        .done_o       (wr_done)
    );

    assign lcd_rw     = 1'b0;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_lcd_text_driver.sv
// tb_lcd_text_driver: directed/randomized self-checking bench for lcd_text_driver
module tb_lcd_text_driver;
    localparam int PU  = 10;
    localparam int E   = 2;
    localparam int CMD = 5;
    localparam int CLR = 20;

    logic         Clk;
    logic         reset;
    logic [255:0] text_in;
    logic         lcd_e, lcd_rs, lcd_rw, init_done, frame_done;
    logic [7:0]   lcd_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = 0;
    int last_fall = 0;
    int rst_cyc = 0;

    logic [255:0] sq_txt = "Square Root     Sqrts a Number  ";
    logic [255:0] all_a  = {32{8'h41}};
    logic [255:0] r1, r2, r3;

    lcd_text_driver #(
        .POWERUP_CYCLES   (PU),
        .E_PULSE_CYCLES   (E),
        .CMD_WAIT_CYCLES  (CMD),
        .CLEAR_WAIT_CYCLES(CLR)
    ) dut (
        .Clk       (Clk),
        .reset     (reset),
        .text_in   (text_in),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data),
        .init_done (init_done),
        .frame_done(frame_done)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Reference: a byte is shown as-is only if printable ASCII, otherwise as a space
    function automatic logic [7:0] exp_char(input logic [255:0] t, input int k);
        logic [7:0] b;
        b = t[255 - 8*k -: 8];
        return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h20;
    endfunction

    function automatic logic [255:0] rand_text();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom();
        return t;
    endfunction

    // Observe one bus write: when E rises, what it carries, how long E stays high,
    // and that rs/data only change in the single setup cycle before E rises.
    task automatic do_write(input logic exp_rs, input logic [7:0] exp_d, input int exp_rise);
        int n, m, nchg, chg, fd;
        logic prs;
        logic [7:0] pd;
        bit stable;
        n = 0; nchg = 0; chg = -1; fd = 0;
        while (lcd_e !== 1'b1 && n < 200) begin
            prs = lcd_rs;
            pd  = lcd_data;
            @(negedge Clk);
            n++;
            if (frame_done === 1'b1) fd++;
            if ({lcd_rs, lcd_data} !== {prs, pd}) begin
                nchg++;
                chg = cyc;
            end
        end
        chk("e_rise_seen", lcd_e, 1'b1);
        chk("e_rise_cycle", cyc, exp_rise);
        chk("rs", lcd_rs, exp_rs);
        chk("data", lcd_data, exp_d);
        chk("rw", lcd_rw, 1'b0);
        chk("setup_only_change", (nchg == 0 || (nchg == 1 && chg == cyc - 1)), 1);
        last_rise = cyc;
        prs = lcd_rs;
        pd  = lcd_data;
        stable = 1'b1;
        m = 0;
        while (lcd_e === 1'b1 && m < 50) begin
            if ({lcd_rs, lcd_data} !== {prs, pd}) stable = 1'b0;
            @(negedge Clk);
            m++;
            if (frame_done === 1'b1) fd++;
        end
        if ({lcd_rs, lcd_data} !== {prs, pd}) stable = 1'b0;
        chk("e_width", m, E);
        chk("pulse_hold", stable, 1'b1);
        chk("stray_frame_done", fd, 0);
        last_fall = cyc;
    endtask

    task automatic init_seq();
        do_write(1'b0, 8'h38, rst_cyc + PU + 1);
        do_write(1'b0, 8'h0C, last_rise + 1 + E + CMD);
        do_write(1'b0, 8'h06, last_rise + 1 + E + CMD);
        do_write(1'b0, 8'h01, last_rise + 1 + E + CMD);
        repeat (CLR - 1) @(negedge Clk);
        chk("init_done_early", init_done, 1'b0);
        @(negedge Clk);
        chk("init_done_rise", init_done, 1'b1);
    endtask

    // One frame: 0x80, 16 chars, 0xC0, 16 chars; first write follows SNAP by one cycle
    task automatic run_frame(input logic [255:0] exp_txt, input bit first, input int chg_at,
                             input logic [255:0] chg_txt, input logic [255:0] nxt_txt);
        do_write(1'b0, 8'h80, last_rise + 1 + E + (first ? CLR : CMD) + 1);
        for (int k = 0; k < 32; k++) begin
            if (k == chg_at) text_in = chg_txt;
            if (k == 16) do_write(1'b0, 8'hC0, last_rise + 1 + E + CMD);
            do_write(1'b1, exp_char(exp_txt, k), last_rise + 1 + E + CMD);
        end
        repeat (CMD - 1) @(negedge Clk);
        chk("frame_done_early", frame_done, 1'b0);
        @(negedge Clk);
        chk("frame_done_pulse", frame_done, 1'b1);
        chk("init_done_hold", init_done, 1'b1);
        text_in = nxt_txt;
    endtask

    initial begin
        int n;
        reset   = 1'b1;
        text_in = sq_txt;
        repeat (3) @(negedge Clk);
        chk("rst_e", lcd_e, 1'b0);
        chk("rst_rs", lcd_rs, 1'b0);
        chk("rst_rw", lcd_rw, 1'b0);
        chk("rst_data", lcd_data, 8'h00);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        reset   = 1'b0;
        rst_cyc = cyc;
        init_seq();

        r1 = rand_text();
        r1[255 - 8*5  -: 8] = 8'h00;
        r1[255 - 8*6  -: 8] = 8'h7E;
        r1[255 - 8*20 -: 8] = 8'h7F;
        r1[255 - 8*7  -: 8] = 8'h20;
        r1[255 - 8*8  -: 8] = 8'h1F;
        run_frame(sq_txt, 1'b1, -1, '0, sq_txt);
        run_frame(sq_txt, 1'b0, -1, '0, r1);
        r2 = rand_text();
        run_frame(r1, 1'b0, -1, '0, r2);
        run_frame(r2, 1'b0, 5, all_a, all_a);
        r3 = rand_text();
        run_frame(all_a, 1'b0, -1, '0, r3);

        n = 0;
        while (lcd_e !== 1'b1 && n < 200) begin
            @(negedge Clk);
            n++;
        end
        chk("mid_reset_e_high", lcd_e, 1'b1);
        reset = 1'b1;
        @(negedge Clk);
        chk("mid_reset_e", lcd_e, 1'b0);
        chk("mid_reset_init_done", init_done, 1'b0);
        chk("mid_reset_data", lcd_data, 8'h00);
        chk("mid_reset_rs", lcd_rs, 1'b0);
        reset   = 1'b0;
        rst_cyc = cyc;
        init_seq();
        run_frame(r3, 1'b1, -1, '0, r3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
